// File: rtl/trellis_phase_detector.sv
// ---------------------------------------------------------------------------
// trellis_phase_detector
//
// Purpose:
//   Decision-directed carrier phase detector for derotated I/Q symbols.
//   Every on-time symbol yields pd = tI - tQ, where each term is the other
//   rail's sample with its sign flipped according to this rail's sign.
//   These per-symbol errors are summed over a window of 2^effExp symbols
//   (effExp = min(avgExp,4)). At the end of each window the scaled sum is
//   saturated to 8 bits and presented with a one-cycle strobe.
//
// Ports:
//   clk          in   1   system clock, rising-edge active
//   reset        in   1   asynchronous reset, active low
//   enable       in   1   detector run enable (quasi-static)
//   avgExp       in   3   log2 of the averaging window; 5..7 behave as 4
//   symEn        in   1   on-time symbol strobe (min spacing 2 clks)
//   iIn, qIn     in  18   derotated I/Q samples, two's complement
//   phaseError   out  8   signed averaged phase error, held between updates
//   symEn_phErr  out  1   one-clk strobe marking a new phaseError value
// ---------------------------------------------------------------------------
module trellis_phase_detector (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [2:0]  avgExp,
  input  logic        symEn,
  input  logic [17:0] iIn,
  input  logic [17:0] qIn,
  output logic [7:0]  phaseError,
  output logic        symEn_phErr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    RUN   = 2'd2
  } stateT;

  stateT              state_q, state_d;

  logic signed [19:0] pd_q, pd_d;
  logic               pdValid_q;
  logic signed [23:0] acc_q, acc_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [2:0]         effExp_q, effExp_d;
  logic [7:0]         phErr_q, phErr_d;
  logic               strobe_q, strobe_d;

  // Sign-extended rails and their products with the opposite rail's sign.
  // Working at 19 bits lets -(-131072) become +131072 without wrapping.
  logic signed [18:0] iExt, qExt, tI, tQ;

  // Window bookkeeping and the end-of-window scaled result.
  logic [2:0]         clampedExp;
  logic [4:0]         windowLen;
  logic               lastSym;
  logic signed [23:0] accNext;
  logic signed [23:0] scaled;
  logic [3:0]         shiftAmt;

  // Per-symbol error term, combinational from the current sample.
  always_comb begin
    iExt = {iIn[17], iIn};
    qExt = {qIn[17], qIn};
    tI   = iIn[17] ? -qExt : qExt;
    tQ   = qIn[17] ? -iExt : iExt;
    pd_d = {tI[18], tI} - {tQ[18], tQ};
  end

  // Error pipeline stage: capture pd on every symbol strobe. Whether the
  // value is consumed is decided by the FSM; a dropped one is simply ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pd_q      <= '0;
      pdValid_q <= 1'b0;
    end else begin
      pdValid_q <= symEn;
      if (symEn) begin
        pd_q <= pd_d;
      end
    end
  end

  // Accumulator arithmetic. The shift is arithmetic, so negative sums round
  // toward minus infinity (e.g. -2048 >>> 11 = -1).
  always_comb begin
    clampedExp = (avgExp > 3'd4) ? 3'd4 : avgExp;
    windowLen  = 5'd1 << effExp_q;
    lastSym    = ((cnt_q + 5'd1) == windowLen);
    accNext    = acc_q + {{4{pd_q[19]}}, pd_q};
    shiftAmt   = {1'b0, effExp_q} + 4'd10;
    scaled     = accNext >>> shiftAmt;
  end

  // Next-state and datapath control. A window dump restarts the next window
  // on the same edge, so there is never an idle cycle between windows.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    effExp_d = effExp_q;
    phErr_d  = phErr_q;
    strobe_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        acc_d = '0;
        cnt_d = '0;
        if (enable) begin
          state_d = ALIGN;
        end
      end

      ALIGN: begin
        acc_d = '0;
        cnt_d = '0;
        if (!enable) begin
          state_d = IDLE;
        end else if (symEn) begin
          // This symbol's pd arrives next cycle and is the window's first.
          state_d  = RUN;
          effExp_d = clampedExp;
        end
      end

      RUN: begin
        if (!enable) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end else if (pdValid_q) begin
          if (lastSym) begin
            acc_d    = '0;
            cnt_d    = '0;
            effExp_d = clampedExp;
            strobe_d = 1'b1;
            if (scaled > 24'sd127) begin
              phErr_d = 8'h7F;
            end else if (scaled < -24'sd128) begin
              phErr_d = 8'h80;
            end else begin
              phErr_d = scaled[7:0];
            end
          end else begin
            acc_d = accNext;
            cnt_d = cnt_q + 5'd1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      effExp_q <= '0;
      phErr_q  <= 8'h00;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      effExp_q <= effExp_d;
      phErr_q  <= phErr_d;
      strobe_q <= strobe_d;
    end
  end

  assign phaseError  = phErr_q;
  assign symEn_phErr = strobe_q;

endmodule

// File: tb/tb_trellis_phase_detector.sv
// ---------------------------------------------------------------------------
// tb_trellis_phase_detector
//
// Self-checking bench. The stimulus side computes each symbol's phase error
// from the sign rules with plain integer arithmetic, groups symbols into
// windows, and pushes the expected averaged value and strobe cycle into a
// queue. An independent monitor pops an entry whenever the DUT strobes.
// ---------------------------------------------------------------------------
module tb_trellis_phase_detector;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [2:0]  avgExp = 3'd0;
  logic        symEn = 1'b0;
  logic [17:0] iIn = '0;
  logic [17:0] qIn = '0;
  logic [7:0]  phaseError;
  logic        symEn_phErr;

  trellis_phase_detector dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .avgExp      (avgExp),
    .symEn       (symEn),
    .iIn         (iIn),
    .qIn         (qIn),
    .phaseError  (phaseError),
    .symEn_phErr (symEn_phErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     value;
    longint cycle;
  } expT;

  expT    sbQ[$];
  int     testsRun = 0;
  int     testsFailed = 0;
  int     strobesSeen = 0;
  int     strobesExpected = 0;
  longint cyc = 0;

  // Reference model state: one averaging window described as a running sum,
  // a symbol count and the window exponent chosen at window start.
  bit     mEnabled = 1'b0;
  bit     mNeedLatch = 1'b0;
  int     mEff = 0;
  int     mCount = 0;
  int     mSum = 0;
  int     mLastPe = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input longint actual, input longint required);
    testsRun++;
    if (actual != required) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, required, cyc);
    end
  endtask

  function automatic int pdOf(input int iv, input int qv);
    int tI;
    int tQ;
    tI = (iv >= 0) ? qv : -qv;
    tQ = (qv >= 0) ? iv : -iv;
    return tI - tQ;
  endfunction

  function automatic int windowResult(input int sum, input int e);
    int s;
    // Integer floor division by 2^(e+10).
    s = sum >>> (e + 10);
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    return s;
  endfunction

  function automatic int clampExp(input int e);
    return (e > 4) ? 4 : e;
  endfunction

  task automatic modelSymbol(input int iv, input int qv, input longint driveCyc);
    expT e;
    if (!mEnabled) return;
    if (mNeedLatch) begin
      mEff       = clampExp(int'(avgExp));
      mNeedLatch = 1'b0;
      mSum       = 0;
      mCount     = 0;
    end
    mSum += pdOf(iv, qv);
    mCount++;
    if (mCount == (1 << mEff)) begin
      e.value = windowResult(mSum, mEff);
      e.cycle = driveCyc + 2;
      sbQ.push_back(e);
      strobesExpected++;
      mLastPe = e.value;
      mSum    = 0;
      mCount  = 0;
      mEff    = clampExp(int'(avgExp));
    end
  endtask

  // One symbol slot: strobe for one clk with the given samples, then idle
  // for 1+extra clks. avgExp only ever changes at the start of a slot.
  task automatic applyStimulus(input int iv, input int qv, input int expNew, input int extra);
    @(posedge clk); #1;
    avgExp = expNew[2:0];
    symEn  = 1'b1;
    iIn    = iv[17:0];
    qIn    = qv[17:0];
    modelSymbol(iv, qv, cyc);
    @(posedge clk); #1;
    symEn = 1'b0;
    iIn   = 18'($urandom);
    qIn   = 18'($urandom);
    repeat (extra) @(posedge clk);
  endtask

  task automatic enableOn();
    @(posedge clk); #1;
    enable     = 1'b1;
    mEnabled   = 1'b1;
    mNeedLatch = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic enableOff();
    @(posedge clk); #1;
    enable   = 1'b0;
    mEnabled = 1'b0;
    mSum     = 0;
    mCount   = 0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("phaseErrorHeld", int'($signed(phaseError)), mLastPe);
  endtask

  task automatic resetPulse();
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    checkOutput("asyncResetPhaseError", phaseError, 0);
    checkOutput("asyncResetStrobe", symEn_phErr, 0);
    sbQ.delete();
    mNeedLatch = mEnabled;
    mSum       = 0;
    mCount     = 0;
    mLastPe    = 0;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  function automatic int randSample();
    if ($urandom_range(0, 15) == 0) return -131072;
    return int'($urandom_range(0, 262143)) - 131072;
  endfunction

  // Monitor: every strobe must match the oldest outstanding expectation,
  // both in value and in the cycle it appears.
  always @(negedge clk) begin
    expT e;
    if (reset && symEn_phErr) begin
      strobesSeen++;
      if (sbQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpectedStrobe: strobe at cycle %0d with phaseError %0d, expected none",
                 cyc, $signed(phaseError));
      end else begin
        e = sbQ.pop_front();
        checkOutput("phaseErrorValue", int'($signed(phaseError)), e.value);
        checkOutput("strobeCycle", cyc, e.cycle);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Power-up: held in reset with arbitrary inputs.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      symEn  = k[0];
      enable = 1'b1;
      iIn    = 18'($urandom);
      qIn    = 18'($urandom);
      avgExp = 3'($urandom);
      #1;
      checkOutput("resetPhaseError", phaseError, 0);
      checkOutput("resetStrobe", symEn_phErr, 0);
    end
    @(posedge clk); #1;
    symEn  = 1'b0;
    enable = 1'b0;
    reset  = 1'b1;

    // Disabled: symbols must produce no strobe.
    for (int k = 0; k < 6; k++) applyStimulus(randSample(), randSample(), 0, 0);

    // Single-symbol windows: pd = -49152 -> -48 per symbol.
    enableOn();
    for (int k = 0; k < 3; k++) applyStimulus(65536, 16384, 0, k);
    enableOff();

    // Saturation: four pd=+131072 symbols -> 128 clipped to 127.
    enableOn();
    for (int k = 0; k < 8; k++) applyStimulus(-131072, 0, 2, 0);
    enableOff();

    // Negative rounding: +3072 then -5120 -> -2048 >>> 11 = -1.
    enableOn();
    for (int k = 0; k < 2; k++) begin
      applyStimulus(0, 3072, 1, 0);
      applyStimulus(5120, 0, 1, 1);
    end
    enableOff();

    // Enable drop mid-window, then a full 8-symbol window.
    enableOn();
    for (int k = 0; k < 5; k++) applyStimulus(randSample(), randSample(), 3, 0);
    enableOff();
    enableOn();
    for (int k = 0; k < 8; k++) applyStimulus(randSample(), randSample(), 3, 0);
    enableOff();

    // Reset mid-window, then a full 16-symbol window.
    enableOn();
    for (int k = 0; k < 10; k++) applyStimulus(randSample(), randSample(), 4, 0);
    resetPulse();
    for (int k = 0; k < 16; k++) applyStimulus(randSample(), randSample(), 4, 0);

    // Randomized traffic with mid-window avgExp changes and enable toggles.
    for (int k = 0; k < 250; k++) begin
      int expNew;
      expNew = int'(avgExp);
      if ($urandom_range(0, 7) == 0) expNew = int'($urandom_range(0, 7));
      if ($urandom_range(0, 39) == 0) begin
        enableOff();
        enableOn();
      end
      applyStimulus(randSample(), randSample(), expNew, int'($urandom_range(0, 2)));
    end

    repeat (10) @(posedge clk);
    #1;
    checkOutput("pendingExpected", sbQ.size(), 0);
    checkOutput("strobeCount", strobesSeen, strobesExpected);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/trellis_phase_detector.md
TRELLIS_PHASE_DETECTOR -- requirements
Module: trellis_phase_detector

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port enable, input, 1 bit: detector run enable (quasi-static register bit).
REQ-004 The block SHALL have port avgExp, input, 3 bits: averaging window of 2^avgExp symbols; values 5-7 act as 4.
REQ-005 The block SHALL have port symEn, input, 1 bit: on-time symbol strobe, one clk wide, minimum spacing 2 clks.
REQ-006 The block SHALL have ports iIn and qIn, input, 18 bits each: derotated I/Q in two's complement, valid when symEn=1.
REQ-007 The block SHALL have port phaseError, output, 8 bits: signed averaged phase error, held between updates.
REQ-008 The block SHALL have port symEn_phErr, output, 1 bit: one-clk strobe marking a new phaseError value.

Function
REQ-009 On a clk edge with symEn=1, the block SHALL register pd = tI - tQ as a 20-bit signed value (pdValid high the next cycle), with:
- tI = qIn if iIn >= 0, else -qIn
- tQ = iIn if qIn >= 0, else -iIn
- negation done at 19 bits, so -(-131072) = +131072
REQ-010 The FSM SHALL have states IDLE, ALIGN and RUN.
REQ-011 In IDLE, accumulator and symbol counter SHALL be held at 0, and no strobes are issued.
REQ-012 IDLE SHALL go to ALIGN when enable=1.
REQ-013 ALIGN SHALL go to RUN on the first symEn; that symbol is the first of a window.
REQ-014 In RUN, each pdValid SHALL add pd to a 24-bit signed accumulator (sign-extended) and increment the symbol counter.
REQ-015 avgExp SHALL be latched as effExp = min(avgExp,4) at each window start (ALIGN exit and every dump); changes mid-window apply to the next window only.
REQ-016 On the pdValid that completes 2^effExp symbols, the block SHALL compute sum = acc + pd and s = sum >>> (effExp+10), with arithmetic shift rounding toward -inf.
REQ-017 phaseError SHALL load s saturated to [-128,+127] on that same edge.
REQ-018 On that same edge, the accumulator and counter SHALL clear and symEn_phErr SHALL assert for that one cycle; there is no dead cycle between windows.
REQ-019 Latency SHALL be exactly 2 clks from the symEn of the last window symbol to symEn_phErr=1, with phaseError valid in the same cycle.
REQ-020 When enable=0 in any state, the FSM SHALL go to IDLE on the next edge:
- the partial window is discarded with no strobe
- phaseError holds its last value
- a pdValid in flight is dropped
REQ-021 The symbol counter SHALL be 5 bits and SHALL never wrap, because a dump always occurs at 2^effExp <= 16.
REQ-022 The accumulator SHALL be sized so it cannot overflow: |pd| <= 131072 and 16 x 131072 < 2^23.
REQ-023 symEn arriving during ALIGN SHALL also launch pd, and that pd SHALL be counted as symbol 1 of the window.

Reset
REQ-024 When reset=0, the block SHALL asynchronously set the FSM to IDLE, and set acc, counter, pd, pdValid, phaseError=8'h00 and symEn_phErr=0.
REQ-025 Reset release SHALL take effect on the first clk edge with reset=1; a reset mid-window discards all partial results.

Verification
REQ-026 The bench SHALL cover power-up: with reset=0 and arbitrary inputs, phaseError=8'h00 and symEn_phErr=0; after release with enable=0 and symEn toggling, no strobe is ever issued.
REQ-027 The bench SHALL cover single-symbol sign handling: avgExp=0, iIn=65536, qIn=16384 gives pd=-49152, so phaseError=8'hD0 (-48) with symEn_phErr exactly 2 clks after symEn, one strobe per symEn.
REQ-028 The bench SHALL cover saturation: avgExp=2, four symbols with iIn=-131072 and qIn=0 gives pd=+131072 each, sum=524288, >>>12=128, so phaseError=8'h7F, one strobe per 4 symEn.
REQ-029 The bench SHALL cover negative rounding: avgExp=1, with symbol A (iIn=0, qIn=3072, pd=+3072) then symbol B (iIn=5120, qIn=0, pd=-5120), gives sum=-2048, >>>11=-1, so phaseError=8'hFF.
REQ-030 The bench SHALL cover enable drop: avgExp=3, enable=0 after 5 symbols, then enable=1, gives no strobe for the partial window; the next strobe follows exactly 8 further symEn counted from the first symEn after re-enable.
REQ-031 The bench SHALL cover reset mid-window: avgExp=4, reset pulsed after 10 symbols, gives outputs 0 immediately (asynchronous), and the first strobe occurs after 16 symEn following enable/ALIGN.
